// File: rtl/des_pkg.sv
// Shared types and constants for the DES block-cipher controller.
// Pure declarations: no latency, no flow control.
package des_pkg;

  localparam int BLK_W = 64;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/des_cbc_ctrl.sv
// ECB/CBC sequencer around a combinational DES core; CORE_LAT+1 cycles from accept to out_valid.
// One block in flight: in_ready drops until the result is taken, out_valid/out_data hold under backpressure.
module des_cbc_ctrl
  import des_pkg::*;
#(
  parameter int unsigned CORE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BLK_W-1:0] cfg_key,
  input  logic             cfg_key_load,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic             cfg_iv_load,
  input  logic             cfg_mode,
  input  logic             cfg_decrypt,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [BLK_W-1:0] core_text,
  output logic [BLK_W-1:0] core_key,
  output logic             core_decrypt,
  input  logic [BLK_W-1:0] core_result
);

  localparam int CNT_W = 4;

  state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  blk_t       key_q, chain_q, in_q, text_q, out_q;
  logic       mode_q, dec_q;
  logic       idle, accept, capture;
  blk_t       chain_eff;

  assign idle    = (state == IDLE);
  assign accept  = idle && in_valid;
  assign capture = (state == RUN) && (cnt == '0);

  // An IV load in the accept cycle must already feed the first CBC XOR.
  assign chain_eff = cfg_iv_load ? cfg_iv : chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = !rst;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == '0) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      chain_q <= '0;
      in_q    <= '0;
      text_q  <= '0;
      out_q   <= '0;
      mode_q  <= MODE_ECB;
      dec_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (idle && cfg_key_load) key_q   <= cfg_key;
      if (idle && cfg_iv_load)  chain_q <= cfg_iv;

      if (accept) begin
        mode_q <= cfg_mode;
        dec_q  <= cfg_decrypt;
        in_q   <= in_data;
        text_q <= (cfg_mode == MODE_CBC && !cfg_decrypt) ? (in_data ^ chain_eff) : in_data;
        cnt    <= CNT_W'(CORE_LAT - 1);
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      // Core inputs have been stable for CORE_LAT cycles here.
      if (capture) begin
        if (mode_q == MODE_CBC && dec_q) begin
          out_q   <= core_result ^ chain_q;
          chain_q <= in_q;
        end else begin
          out_q <= core_result;
          if (mode_q == MODE_CBC) chain_q <= core_result;
        end
      end
    end
  end

  assign core_text    = text_q;
  assign core_key     = key_q;
  assign core_decrypt = dec_q;
  assign out_data     = out_q;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Bench for des_cbc_ctrl with a behavioural DES core standing in for the datapath.
module tb_des_cbc_ctrl;

  localparam int CL = 2;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  localparam int IP_T[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                              62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                              61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                              38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                              34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                             16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,     19,13,30,6,22,11,4,25};
  localparam int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                               19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                               14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                               41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH_T[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX[512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [63:0] des_fn(input logic [63:0] txt, input logic [63:0] key, input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk[16];
    logic [47:0] e, k;
    logic [63:0] ip, pre, res;
    logic [31:0] l, r, f, s, t;
    logic [5:0]  six;
    int row, col;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < SH_T[n]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[n][6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    end
    for (int i = 0; i < 64; i++) ip[6'(63 - i)] = txt[6'(64 - IP_T[i])];
    l = ip[63:32];
    r = ip[31:0];
    for (int n = 0; n < 16; n++) begin
      k = dec ? sk[15 - n] : sk[n];
      for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[i])];
      e = e ^ k;
      for (int b = 0; b < 8; b++) begin
        six = e[6'(47 - 6 * b) -: 6];
        row = int'({six[5], six[0]});
        col = int'(six[4:1]);
        s[5'(31 - 4 * b) -: 4] = 4'(SBOX[b * 64 + row * 16 + col]);
      end
      for (int i = 0; i < 32; i++) f[5'(31 - i)] = s[5'(32 - P_T[i])];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[6'(63 - i)] = pre[6'(64 - FP_T[i])];
    return res;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cfg_key, cfg_iv, in_data, out_data, core_text, core_key, core_result;
  logic        cfg_key_load, cfg_iv_load, cfg_mode, cfg_decrypt;
  logic        in_valid, in_ready, out_valid, out_ready, busy, core_decrypt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign core_result = des_fn(core_text, core_key, core_decrypt);

  des_cbc_ctrl #(.CORE_LAT(CL)) dut (
    .clk(clk), .rst(rst),
    .cfg_key(cfg_key), .cfg_key_load(cfg_key_load),
    .cfg_iv(cfg_iv), .cfg_iv_load(cfg_iv_load),
    .cfg_mode(cfg_mode), .cfg_decrypt(cfg_decrypt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .core_text(core_text), .core_key(core_key),
    .core_decrypt(core_decrypt), .core_result(core_result)
  );

  task automatic load_key(input logic [63:0] k);
    cfg_key = k; cfg_key_load = 1'b1;
    @(posedge clk); #1;
    cfg_key_load = 1'b0;
  endtask

  task automatic load_iv(input logic [63:0] v);
    cfg_iv = v; cfg_iv_load = 1'b1;
    @(posedge clk); #1;
    cfg_iv_load = 1'b0;
  endtask

  // Presents one block from IDLE and waits for out_valid; completes the handshake only if out_ready is high.
  task automatic run_block(input logic [63:0] d, input logic m, input logic dec,
                           output logic [63:0] r, output int lat, output bit to);
    in_data = d; cfg_mode = m; cfg_decrypt = dec; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_key_load = 1'b0; cfg_iv_load = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
    r  = out_data;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if ({core_text, core_key, out_data, core_decrypt} !== '0) begin
      bad++; $display("FAIL rst_regs text=%h key=%h out=%h dec=%b exp=all zero", core_text, core_key, out_data, core_decrypt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_ecb_encrypt;
    logic [63:0] r; int lat; bit to;
    load_key(K1);
    run_block(P1, 1'b0, 1'b0, r, lat, to);
    total++; if (to) begin bad++; $display("FAIL ecb_enc_timeout got=no out_valid exp=out_valid"); end
    total++; if (r !== C1) begin bad++; $display("FAIL ecb_enc_data got=%h exp=%h", r, C1); end
    total++; if (lat !== CL + 1) begin bad++; $display("FAIL ecb_enc_latency got=%0d exp=%0d", lat, CL + 1); end
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ecb_enc_release got in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ecb_decrypt;
    logic [63:0] r; int lat; bit to;
    run_block(C1, 1'b0, 1'b1, r, lat, to);
    total++; if (to || r !== P1) begin bad++; $display("FAIL ecb_dec_data got=%h timeout=%b exp=%h", r, to, P1); end
  endtask

  task automatic test_cbc;
    logic [63:0] r, c1, c2, x; int lat; bit to;
    load_iv(64'h0);
    run_block(P1, 1'b1, 1'b0, c1, lat, to);
    total++; if (to || c1 !== C1) begin bad++; $display("FAIL cbc_enc_blk1 got=%h exp=%h", c1, C1); end
    x = 64'hFEDCBA9876543210;
    run_block(x, 1'b0, 1'b0, r, lat, to);
    total++; if (to || r !== des_fn(x, K1, 1'b0)) begin bad++; $display("FAIL ecb_between got=%h exp=%h", r, des_fn(x, K1, 1'b0)); end
    run_block(P1, 1'b1, 1'b0, c2, lat, to);
    total++; if (to || c2 !== des_fn(P1 ^ C1, K1, 1'b0)) begin
      bad++; $display("FAIL cbc_enc_blk2 got=%h exp=%h", c2, des_fn(P1 ^ C1, K1, 1'b0));
    end
    load_iv(64'h0);
    run_block(c1, 1'b1, 1'b1, r, lat, to);
    total++; if (to || r !== P1) begin bad++; $display("FAIL cbc_dec_blk1 got=%h exp=%h", r, P1); end
    run_block(c2, 1'b1, 1'b1, r, lat, to);
    total++; if (to || r !== P1) begin bad++; $display("FAIL cbc_dec_blk2 got=%h exp=%h", r, P1); end
  endtask

  task automatic test_backpressure;
    logic [63:0] r; int lat; bit to;
    out_ready = 1'b0;
    run_block(P1, 1'b0, 1'b0, r, lat, to);
    total++; if (to || r !== C1) begin bad++; $display("FAIL bp_first got=%h exp=%h", r, C1); end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin cfg_key = K2; cfg_key_load = 1'b1; end
      if (c == 5) begin in_data = 64'hFFFFFFFFFFFFFFFF; in_valid = 1'b1; end
      @(posedge clk); #1;
      cfg_key_load = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_data !== C1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL bp_hold cyc=%0d got valid=%b data=%h in_ready=%b busy=%b exp=1/%h/0/1",
                        c, out_valid, out_data, in_ready, busy, C1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
    end
    run_block(P1, 1'b0, 1'b0, r, lat, to);
    total++; if (to || r !== C1) begin bad++; $display("FAIL bp_old_key got=%h exp=%h", r, C1); end
  endtask

  task automatic test_reset_mid_run;
    logic [63:0] r; int lat; bit to;
    in_data = P1; cfg_mode = 1'b0; cfg_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_run_busy got=%b exp=1", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctrl got valid=%b busy=%b in_ready=%b exp=0/0/0", out_valid, busy, in_ready);
    end
    total++; if (core_text !== 64'h0 || core_key !== 64'h0 || out_data !== 64'h0) begin
      bad++; $display("FAIL mid_rst_regs got text=%h key=%h out=%h exp=0", core_text, core_key, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL post_rst_idle cyc=%0d got valid=%b in_ready=%b exp=0/1", c, out_valid, in_ready);
      end
    end
    load_key(K1);
    run_block(P1, 1'b0, 1'b0, r, lat, to);
    total++; if (to || r !== C1) begin bad++; $display("FAIL post_rst_ecb got=%h exp=%h", r, C1); end
    run_block(P1, 1'b1, 1'b0, r, lat, to);
    total++; if (to || r !== C1) begin bad++; $display("FAIL post_rst_chain_zero got=%h exp=%h", r, C1); end
  endtask

  task automatic test_key_same_cycle;
    logic [63:0] r; int lat; bit to;
    cfg_key = K2; cfg_key_load = 1'b1;
    run_block(P2, 1'b0, 1'b0, r, lat, to);
    total++; if (to || r !== C2) begin bad++; $display("FAIL same_cycle_key got=%h exp=%h", r, C2); end
    total++; if (lat !== CL + 1) begin bad++; $display("FAIL same_cycle_latency got=%0d exp=%0d", lat, CL + 1); end
  endtask

  initial begin
    rst = 1'b1;
    cfg_key = '0; cfg_key_load = 1'b0; cfg_iv = '0; cfg_iv_load = 1'b0;
    cfg_mode = 1'b0; cfg_decrypt = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    test_reset();
    test_ecb_encrypt();
    test_ecb_decrypt();
    test_cbc();
    test_backpressure();
    test_reset_mid_run();
    test_key_same_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/des_cbc_ctrl.md
Name: des_cbc_ctrl

Overview:
Sequencing controller that wraps the combinational 64-bit DES datapath (initial permutation, key schedule, round stack, final permutation) and runs it as a block-cipher engine with a valid/ready stream interface. It supports ECB and CBC modes for both encryption and decryption, and holds the key, IV and chaining register. Each block is presented to the core for CORE_LAT cycles, treated as a multicycle path, before the result is captured. It sits between the system bus/stream and the DES core instance.

Parameters:
CORE_LAT, 2, number of cycles core inputs are held stable before capturing core output (legal range 1..15).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cfg_key  input  64  cipher key with parity bits; sampled on cfg_key_load
cfg_key_load  input  1  load cfg_key into key register; honoured only in IDLE
cfg_iv  input  64  initialisation vector; sampled on cfg_iv_load
cfg_iv_load  input  1  load cfg_iv into chain register; honoured only in IDLE
cfg_mode  input  1  0 = ECB, 1 = CBC; sampled at block accept
cfg_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled at block accept
in_data  input  64  input block
in_valid  input  1  input block valid
in_ready  output  1  controller can accept a block
out_data  output  64  result block
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
busy  output  1  high whenever state is not IDLE
core_text  output  64  text driven to the DES core
core_key  output  64  key driven to the DES core
core_decrypt  output  1  encrypt/decrypt select to the DES core
core_result  input  64  combinational DES core output

Behaviour:
- Reset (async, rst=1): state IDLE; key register, chain register, core_text, out_data and wait counter = 0; in_ready=0 while rst is high, then 1 in IDLE; out_valid=0; busy=0; core_decrypt=0.
- FSM states are IDLE, RUN and HOLD.
- IDLE: in_ready=1. On in_valid, latch mode_q and dec_q from cfg_mode and cfg_decrypt, and latch in_q. Then go to RUN with counter = CORE_LAT-1.
- core_text during RUN:
  - ECB: in_q.
  - CBC encrypt: in_q ^ chain.
  - CBC decrypt: in_q.
- core_text, core_key and core_decrypt are registered and stay constant for the whole of RUN.
- RUN: decrement the counter each cycle. When the counter reaches 0, capture the result, go to HOLD, and assert out_valid on the next cycle. Block latency from the in_valid&&in_ready cycle to the first out_valid cycle is CORE_LAT+1 cycles.
- Result capture:
  - ECB: out_data = core_result.
  - CBC encrypt: out_data = core_result; chain <= core_result.
  - CBC decrypt: out_data = core_result ^ chain; chain <= in_q.
- HOLD: out_valid=1 and out_data stable until out_ready. On out_valid&&out_ready, return to IDLE. in_ready stays 0 in HOLD, so there is no overlap and throughput is one block per CORE_LAT+2 cycles minimum.
- Config loads:
  - cfg_key_load and cfg_iv_load are honoured only in IDLE; in RUN or HOLD they are ignored with no side effects.
  - If a load and in_valid coincide in IDLE, the load takes effect first, so the accepted block uses the new key/IV.
- ECB blocks do not modify the chain register.
- Mode or direction changes between blocks are allowed. The chain register continues from its last value unless the IV is reloaded.
- Reset mid-operation: the block is discarded, all state clears, and no partial output is produced.
- out_valid never deasserts without a handshake, and out_data never changes while out_valid=1.

Decomposition:
- Shared package des_pkg holds:
  - FSM state enum (IDLE, RUN, HOLD);
  - mode constants MODE_ECB=0 and MODE_CBC=1;
  - block width 64.
- The block is a single module with no sub-module. The DES core is instantiated alongside it at the parent level and connected through the core_* ports.
- The test bench instantiates des_cbc_ctrl together with the existing DES top.

Test Plan:
1. ECB encrypt: key 133457799BBCDFF1, in 0123456789ABCDEF, out_ready=1 -> out_data 85E813540F0AB405, out_valid first asserted exactly CORE_LAT+1 cycles after accept.
2. ECB decrypt: same key, in 85E813540F0AB405 -> out_data 0123456789ABCDEF.
3. CBC encrypt two blocks: IV 0000000000000000, both blocks 0123456789ABCDEF:
   - block 1 -> 85E813540F0AB405;
   - block 2 -> DES(0123456789ABCDEF ^ 85E813540F0AB405), matching the reference model;
   - CBC decrypt of both outputs after an IV reload to 0 -> original plaintexts.
4. Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid and out_data stable, in_ready=0, a cfg_key_load pulse is ignored (next block still uses the old key).
5. Reset mid-RUN: assert rst 1 cycle after accept -> out_valid=0, busy=0, chain=0 immediately. A subsequent block produces the correct ECB result with the reloaded key.
6. Same-cycle key load and in_valid in IDLE -> the block is encrypted with the newly loaded key.
